// File: rtl/time_set_ctrl.sv
// Clock time-of-day keeper with button-driven set modes (hour, minute, day) and idle timeout.
// Optional build macro AUTO_REPEAT_EN adds auto-repeat while btn_inc is held in a set state.
module time_set_ctrl #(
    parameter int unsigned TIMEOUT    = 30,
    parameter int unsigned REPEAT_DLY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic       count_day,
    output logic       set_day,
    output logic [1:0] mode,
    output logic       blink
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_DAY  = 2'd3
    } mode_e;

    if (TIMEOUT < 2 || TIMEOUT > 255 || REPEAT_DLY < 1 || REPEAT_DLY > 15) begin : g_bad_param
        $error("time_set_ctrl: TIMEOUT or REPEAT_DLY out of range");
    end

    localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);

    mode_e      state_q, state_d;
    logic [5:0] sec_q, sec_d;
    logic [5:0] min_q, min_d;
    logic [4:0] hour_q, hour_d;
    logic       count_day_q, count_day_d;
    logic       set_day_q, set_day_d;
    logic       blink_q, blink_d;
    logic [7:0] idle_q, idle_d;
    logic       mode_prev_q, mode_prev_d;
    logic       inc_prev_q, inc_prev_d;

    logic mode_edge, inc_edge, inc_evt, activity;

    assign mode_edge = btn_mode & ~mode_prev_q;
    assign inc_edge  = btn_inc & ~inc_prev_q;

`ifdef AUTO_REPEAT_EN
    localparam logic [3:0] RPT_LAST = 4'(REPEAT_DLY);

    logic [3:0] rpt_q, rpt_d;
    logic       rpt_evt, inc_held;

    // Holding counts ticks up to RPT_LAST, after which every tick yields one extra inc.
    always_comb begin
        inc_held = btn_inc & inc_prev_q;
        rpt_d    = rpt_q;
        rpt_evt  = 1'b0;
        if (state_q == RUN || !inc_held || mode_edge) begin
            rpt_d = 4'd0;
        end else if (tick_1hz) begin
            if (rpt_q == RPT_LAST) rpt_evt = 1'b1;
            else rpt_d = rpt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) rpt_q <= 4'd0;
        else rpt_q <= rpt_d;
    end

    assign inc_evt  = inc_edge | rpt_evt;
    assign activity = mode_edge | inc_edge | inc_held;
`else
    assign inc_evt  = inc_edge;
    assign activity = mode_edge | inc_edge;
`endif

    // Mode edge has priority over everything, so a simultaneous inc is dropped.
    always_comb begin
        state_d     = state_q;
        sec_d       = sec_q;
        min_d       = min_q;
        hour_d      = hour_q;
        count_day_d = 1'b0;
        set_day_d   = 1'b0;
        blink_d     = blink_q;
        idle_d      = idle_q;
        mode_prev_d = btn_mode;
        inc_prev_d  = btn_inc;

        if (mode_edge) begin
            state_d = mode_e'(state_q + 2'd1);
            blink_d = 1'b0;
            idle_d  = 8'd0;
            if (state_q == RUN) sec_d = 6'd0;
        end else if (state_q == RUN) begin
            blink_d = 1'b0;
            idle_d  = 8'd0;
            if (tick_1hz) begin
                if (sec_q == 6'd59) begin
                    sec_d = 6'd0;
                    if (min_q == 6'd59) begin
                        min_d = 6'd0;
                        if (hour_q == 5'd23) begin
                            hour_d      = 5'd0;
                            count_day_d = 1'b1;
                        end else begin
                            hour_d = hour_q + 5'd1;
                        end
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end
        end else if (tick_1hz && !activity && idle_q == IDLE_LAST) begin
            state_d = RUN;
            blink_d = 1'b0;
            idle_d  = 8'd0;
        end else begin
            if (activity) idle_d = 8'd0;
            else if (tick_1hz) idle_d = idle_q + 8'd1;
            if (tick_1hz) blink_d = ~blink_q;
            if (inc_evt) begin
                case (state_q)
                    SET_HOUR: hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                    SET_MIN:  min_d  = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                    SET_DAY:  set_day_d = 1'b1;
                    default:  ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= RUN;
            sec_q       <= 6'd0;
            min_q       <= 6'd0;
            hour_q      <= 5'd0;
            count_day_q <= 1'b0;
            set_day_q   <= 1'b0;
            blink_q     <= 1'b0;
            idle_q      <= 8'd0;
            mode_prev_q <= 1'b0;
            inc_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            count_day_q <= count_day_d;
            set_day_q   <= set_day_d;
            blink_q     <= blink_d;
            idle_q      <= idle_d;
            mode_prev_q <= mode_prev_d;
            inc_prev_q  <= inc_prev_d;
        end
    end

    assign sec       = sec_q;
    assign min       = min_q;
    assign hour      = hour_q;
    assign count_day = count_day_q;
    assign set_day   = set_day_q;
    assign mode      = state_q;
    assign blink     = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl; results packed as {mode,hour,min,sec,count_day,set_day,blink}.
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_1hz;
    logic       btn_mode;
    logic       btn_inc;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       count_day;
    logic       set_day;
    logic [1:0] mode;
    logic       blink;

    // clock / reset
    always #5 clk = ~clk;

    time_set_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_1hz  (tick_1hz),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .sec       (sec),
        .min       (min),
        .hour      (hour),
        .count_day (count_day),
        .set_day   (set_day),
        .mode      (mode),
        .blink     (blink)
    );

    logic [21:0] obs;
    assign obs = {mode, hour, min, sec, count_day, set_day, blink};

    logic [21:0] exp_q[$];
    logic [21:0] exp_v;
    int n_checks = 0;
    int n_pass   = 0;
    int cd_cnt   = 0;
    int sd_cnt   = 0;
    int viol     = 0;
    int base;
    int exp_min;

    // pulse monitor, mid-cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            if (count_day) cd_cnt++;
            if (set_day) sd_cnt++;
            if ((count_day && set_day) || (count_day && mode != 2'd0) || (set_day && mode != 2'd3))
                viol++;
        end
    end

    function automatic logic [21:0] pack(input logic [1:0] m, input logic [4:0] h,
                                         input logic [5:0] mi, input logic [5:0] s,
                                         input logic cd, input logic sd, input logic bl);
        return {m, h, mi, s, cd, sd, bl};
    endfunction

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_ticks(input int n);
        tick_1hz = 1'b1;
        repeat (n) step();
        tick_1hz = 1'b0;
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        step();
        btn_mode = 1'b0;
        step();
    endtask

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) begin
            btn_inc = 1'b1;
            step();
            btn_inc = 1'b0;
            step();
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b1;
        btn_inc  = 1'b1;
        tick_1hz = 1'b1;
        exp_q.push_back(pack(2'd0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0));
        step();
        step();
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) $display("FAIL reset_hold: got %h expected %h", obs, exp_v);
        else n_pass++;
        rst_n    = 1'b0;
        btn_inc  = 1'b0;
        tick_1hz = 1'b0;
        exp_q.push_back(pack(2'd0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0));
        step();
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) $display("FAIL reset_release: got %h expected %h", obs, exp_v);
        else n_pass++;
    endtask

    task automatic test_run_count();
        exp_q.push_back(pack(2'd0, 5'd1, 6'd1, 6'd1, 1'b0, 1'b0, 1'b0));
        run_ticks(3661);
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) $display("FAIL run_3661: got %h expected %h", obs, exp_v);
        else n_pass++;
        n_checks++;
        if (cd_cnt !== 0) $display("FAIL run_no_count_day: got %0d expected 0", cd_cnt);
        else n_pass++;
    endtask

    task automatic test_rollover();
        exp_q.push_back(pack(2'd1, 5'd1, 6'd1, 6'd0, 1'b0, 1'b0, 1'b0));
        press_mode();
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) $display("FAIL enter_set_hour: got %h expected %h", obs, exp_v);
        else n_pass++;
        press_inc(22);
        press_mode();
        press_inc(58);
        exp_q.push_back(pack(2'd0, 5'd23, 6'd59, 6'd0, 1'b0, 1'b0, 1'b0));
        press_mode();
        press_mode();
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) $display("FAIL preset_23_59: got %h expected %h", obs, exp_v);
        else n_pass++;
        exp_q.push_back(pack(2'd0, 5'd23, 6'd59, 6'd59, 1'b0, 1'b0, 1'b0));
        run_ticks(59);
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) $display("FAIL at_23_59_59: got %h expected %h", obs, exp_v);
        else n_pass++;
        exp_q.push_back(pack(2'd0, 5'd0, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0));
        run_ticks(1);
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) $display("FAIL midnight_rollover: got %h expected %h", obs, exp_v);
        else n_pass++;
        exp_q.push_back(pack(2'd0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0));
        step();
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) $display("FAIL count_day_one_clk: got %h expected %h", obs, exp_v);
        else n_pass++;
        n_checks++;
        if (cd_cnt !== 1) $display("FAIL count_day_pulses: got %0d expected 1", cd_cnt);
        else n_pass++;
    endtask

    task automatic test_set_hour();
        press_mode();
        press_inc(10);
        press_mode();
        press_inc(20);
        press_mode();
        press_mode();
        exp_q.push_back(pack(2'd0, 5'd10, 6'd20, 6'd35, 1'b0, 1'b0, 1'b0));
        run_ticks(35);
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) $display("FAIL at_10_20_35: got %h expected %h", obs, exp_v);
        else n_pass++;
        exp_q.push_back(pack(2'd1, 5'd10, 6'd20, 6'd0, 1'b0, 1'b0, 1'b0));
        press_mode();
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) $display("FAIL set_hour_sec_clear: got %h expected %h", obs, exp_v);
        else n_pass++;
        exp_q.push_back(pack(2'd1, 5'd1, 6'd20, 6'd0, 1'b0, 1'b0, 1'b0));
        press_inc(15);
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) $display("FAIL hour_wrap: got %h expected %h", obs, exp_v);
        else n_pass++;
        exp_q.push_back(pack(2'd1, 5'd1, 6'd20, 6'd0, 1'b0, 1'b0, 1'b1));
        run_ticks(1);
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) $display("FAIL blink_toggle_hold: got %h expected %h", obs, exp_v);
        else n_pass++;
        run_ticks(1);
        n_checks++;
        if (cd_cnt !== 1) $display("FAIL set_no_count_day: got %0d expected 1", cd_cnt);
        else n_pass++;
    endtask

    task automatic test_set_day();
        press_mode();
        press_mode();
        base = sd_cnt;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(pack(2'd3, 5'd1, 6'd20, 6'd0, 1'b0, 1'b1, 1'b0));
            btn_inc = 1'b1;
            step();
            exp_v = exp_q.pop_front(); n_checks++;
            if (obs !== exp_v) $display("FAIL set_day_pulse_%0d: got %h expected %h", i, obs, exp_v);
            else n_pass++;
            exp_q.push_back(pack(2'd3, 5'd1, 6'd20, 6'd0, 1'b0, 1'b0, 1'b0));
            btn_inc = 1'b0;
            step();
            exp_v = exp_q.pop_front(); n_checks++;
            if (obs !== exp_v) $display("FAIL set_day_end_%0d: got %h expected %h", i, obs, exp_v);
            else n_pass++;
        end
        exp_q.push_back(pack(2'd0, 5'd1, 6'd20, 6'd0, 1'b0, 1'b0, 1'b0));
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        step();
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) $display("FAIL mode_beats_inc: got %h expected %h", obs, exp_v);
        else n_pass++;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        step();
        n_checks++;
        if (sd_cnt - base !== 3) $display("FAIL set_day_count: got %0d expected 3", sd_cnt - base);
        else n_pass++;
    endtask

    task automatic test_timeout();
        press_mode();
        press_mode();
        exp_q.push_back(pack(2'd2, 5'd1, 6'd20, 6'd0, 1'b0, 1'b0, 1'b1));
        run_ticks(29);
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) $display("FAIL before_timeout: got %h expected %h", obs, exp_v);
        else n_pass++;
        exp_q.push_back(pack(2'd0, 5'd1, 6'd20, 6'd0, 1'b0, 1'b0, 1'b0));
        run_ticks(1);
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) $display("FAIL timeout_to_run: got %h expected %h", obs, exp_v);
        else n_pass++;
        exp_q.push_back(pack(2'd0, 5'd1, 6'd20, 6'd1, 1'b0, 1'b0, 1'b0));
        run_ticks(1);
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) $display("FAIL resume_after_timeout: got %h expected %h", obs, exp_v);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        press_mode();
        press_inc(2);
        exp_q.push_back(pack(2'd1, 5'd3, 6'd20, 6'd0, 1'b0, 1'b0, 1'b0));
        step();
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) $display("FAIL pre_reset_state: got %h expected %h", obs, exp_v);
        else n_pass++;
        exp_q.push_back(pack(2'd0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0));
        btn_inc = 1'b1;
        rst_n   = 1'b1;
        step();
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) $display("FAIL reset_beats_inc: got %h expected %h", obs, exp_v);
        else n_pass++;
        exp_q.push_back(pack(2'd0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0));
        rst_n   = 1'b0;
        btn_inc = 1'b0;
        step();
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) $display("FAIL after_mid_reset: got %h expected %h", obs, exp_v);
        else n_pass++;
    endtask

    task automatic test_repeat();
`ifdef AUTO_REPEAT_EN
        exp_min = 5;
`else
        exp_min = 1;
`endif
        press_mode();
        press_mode();
        exp_q.push_back(pack(2'd2, 5'd0, 6'(exp_min), 6'd0, 1'b0, 1'b0, 1'b0));
        btn_inc = 1'b1;
        step();
        run_ticks(6);
        btn_inc = 1'b0;
        step();
        exp_v = exp_q.pop_front(); n_checks++;
        if (obs !== exp_v) $display("FAIL held_inc: got %h expected %h", obs, exp_v);
        else n_pass++;
    endtask

    task automatic test_invariants();
        n_checks++;
        if (viol !== 0) $display("FAIL pulse_rules: got %0d violations expected 0", viol);
        else n_pass++;
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        else n_pass++;
    endtask

    initial begin
        rst_n    = 1'b0;
        tick_1hz = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        step();
        test_reset();
        test_run_count();
        test_rollover();
        test_set_hour();
        test_set_day();
        test_timeout();
        test_reset_mid();
        test_repeat();
        test_invariants();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
